// File: rtl/pll_reset_sequencer_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL_VIDEO = 3'd3,
        ST_RUN       = 3'd4,
        ST_CPU_HOLD  = 3'd5
    } state_e;

    localparam int                 LLC_W   = 8;
    localparam logic [LLC_W-1:0]   LLC_SAT = 8'd255;

    // Bits needed to count 0 .. n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL status/control and staged reset outputs of the sequencer.
interface pll_reset_sequencer_if;
    import pll_reset_pkg::*;

    logic             pll_locked;
    logic             user_reset;
    logic             pll_rst;
    logic             rst_video;
    logic             rst_cpu;
    logic             ready;
    logic [LLC_W-1:0] lock_loss_count;
    logic [2:0]       state_dbg;

    modport master (
        input  pll_locked, user_reset,
        output pll_rst, rst_video, rst_cpu, ready, lock_loss_count, state_dbg
    );

    modport slave (
        output pll_locked, user_reset,
        input  pll_rst, rst_video, rst_cpu, ready, lock_loss_count, state_dbg
    );
endinterface

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level, cleared by rst.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= '0;
        else     r_sync <= {r_sync[STAGES-2:0], i_d};
    end

    assign o_q = r_sync[STAGES-1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// Holds the PLL in reset, waits for a stable lock, then releases video and CPU resets in stages.
//   state        | meaning
//   PLL_RST      | pulsing pll_rst high
//   WAIT_LOCK    | waiting for locked, timeout re-resets the PLL
//   STABLE       | counting consecutive locked cycles
//   REL_VIDEO    | video out of reset, CPU still held
//   RUN          | everything released, ready=1
//   CPU_HOLD     | CPU held by user_reset plus a tail
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGE_GAP_CYCLES    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    pll_reset_sequencer_if.master bus
);
    localparam int MAX_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int MAX_B  = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int CNT_W  = cnt_width((MAX_A > MAX_B) ? MAX_A : MAX_B);

    localparam logic [CNT_W-1:0] TC_PLL_RST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_TIMEOUT = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_STABLE  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TC_GAP     = CNT_W'(STAGE_GAP_CYCLES - 1);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [LLC_W-1:0] r_llc, w_llc_nxt;
    logic             r_pll_rst, r_rst_video, r_rst_cpu, r_ready;
    logic             w_locked_s, w_user_reset_s, w_lost;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_locked (
        .clk (clk), .rst (rst), .i_d (bus.pll_locked), .o_q (w_locked_s)
    );

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_user (
        .clk (clk), .rst (rst), .i_d (bus.user_reset), .o_q (w_user_reset_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_PLL_RST;
            r_cnt   <= '0;
            r_llc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_llc   <= w_llc_nxt;
        end
    end

    // Outputs are decoded from the next state so they change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pll_rst   <= 1'b1;
            r_rst_video <= 1'b1;
            r_rst_cpu   <= 1'b1;
            r_ready     <= 1'b0;
        end else begin
            r_pll_rst   <= (w_state_nxt == ST_PLL_RST);
            r_rst_video <= !(w_state_nxt inside {ST_REL_VIDEO, ST_RUN, ST_CPU_HOLD});
            r_rst_cpu   <= (w_state_nxt != ST_RUN);
            r_ready     <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_llc_nxt   = r_llc;
        w_lost      = !w_locked_s && (r_state inside {ST_REL_VIDEO, ST_RUN, ST_CPU_HOLD});

        case (r_state)
            ST_PLL_RST: begin
                if (r_cnt == TC_PLL_RST) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TC_TIMEOUT) begin
                    w_state_nxt = ST_PLL_RST;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == TC_STABLE) begin
                    w_state_nxt = ST_REL_VIDEO;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_REL_VIDEO: begin
                if (r_cnt == TC_GAP) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (w_user_reset_s) begin
                    w_state_nxt = ST_CPU_HOLD;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CPU_HOLD: begin
                if (w_user_reset_s) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == TC_GAP) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_PLL_RST;
                w_cnt_nxt   = '0;
            end
        endcase

        // Lock loss after first release overrides user reset and any terminal count.
        if (w_lost) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_cnt_nxt   = '0;
            if (r_llc != LLC_SAT) w_llc_nxt = r_llc + LLC_W'(1);
        end
    end

    assign bus.pll_rst         = r_pll_rst;
    assign bus.rst_video       = r_rst_video;
    assign bus.rst_cpu         = r_rst_cpu;
    assign bus.ready           = r_ready;
    assign bus.lock_loss_count = r_llc;
    assign bus.state_dbg       = r_state;
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Sits directly downstream of the system PLL. It drives the PLL's reset and watches its `locked` output. Once lock has held long enough, it releases the design's resets in stages: video domain first, then CPU. On lock loss or a lock timeout it re-runs the sequence, and it counts lock-loss events for debug.

Parameters:
SYNC_STAGES, 2, flops in the `pll_locked` / `user_reset` synchronisers (min 2)
PLL_RST_CYCLES, 16, clk cycles `pll_rst` is held high per PLL reset pulse
LOCK_TIMEOUT_CYCLES, 1000000, WAIT_LOCK cycles before the PLL is re-reset
LOCK_STABLE_CYCLES, 1024, consecutive synchronised-locked cycles required
STAGE_GAP_CYCLES, 64, cycles between the `rst_video` and `rst_cpu` releases; also the `rst_cpu` tail after `user_reset`

Ports:
clk  in  1  free-running 50 MHz board reference; the same net that feeds the PLL refclk
rst  in  1  asynchronous, active-high reset
pll_locked  in  1  PLL locked; asynchronous to clk
user_reset  in  1  OSD/HPS CPU reset request; asynchronous to clk
pll_rst  out  1  PLL reset
rst_video  out  1  active-high video-domain reset; consumer re-synchronises it
rst_cpu  out  1  active-high CPU-domain reset; consumer re-synchronises it
ready  out  1  high only in RUN
lock_loss_count  out  8  saturating count of lock losses after first release
state_dbg  out  3  current state encoding

Behaviour:
- All outputs are registered. Every counter is wide enough for its parameter.
- On rst (async): state=PLL_RST, counter=0, pll_rst=1, rst_video=1, rst_cpu=1, ready=0, lock_loss_count=0. Synchroniser flops clear to 0.
- `locked_s` and `user_reset_s` are SYNC_STAGES-flop synchronised copies of their inputs. All decisions below use only the synchronised copies.
- PLL_RST:
  - pll_rst=1, rst_video=1, rst_cpu=1.
  - Stays exactly PLL_RST_CYCLES cycles, then goes to WAIT_LOCK.
  - pll_rst is low from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - Resets stay high.
  - locked_s=1 -> STABLE, with the counter cleared.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles in WAIT_LOCK -> PLL_RST (retry). This retry repeats indefinitely.
- STABLE:
  - The counter increments each cycle while locked_s=1.
  - locked_s=0 -> WAIT_LOCK; the timeout counter restarts from 0 and lock_loss_count does not increment.
  - After LOCK_STABLE_CYCLES consecutive locked cycles -> REL_VIDEO.
- REL_VIDEO:
  - rst_video=0 from the first cycle in this state; rst_cpu=1.
  - After STAGE_GAP_CYCLES cycles -> RUN.
- RUN:
  - rst_video=0, rst_cpu=0, ready=1, all from the first RUN cycle.
  - user_reset_s=1 -> CPU_HOLD.
- CPU_HOLD:
  - rst_cpu=1 and ready=0 from the first cycle; rst_video stays 0.
  - The counter is held at 0 while user_reset_s=1.
  - After user_reset_s falls, STAGE_GAP_CYCLES cycles -> RUN.
  - user_reset_s re-asserting during the tail restarts the hold.
- Lock loss: locked_s=0 in REL_VIDEO, RUN or CPU_HOLD:
  - Next cycle: state=WAIT_LOCK, rst_video=1, rst_cpu=1, ready=0.
  - lock_loss_count increments, saturating at 255.
  - Lock loss has priority over user_reset and over any terminal count reached in the same cycle.
- user_reset is ignored in PLL_RST, WAIT_LOCK and STABLE, where resets are already asserted.
- rst asserted mid-sequence: immediate return to the reset values above.
- state_dbg encoding: PLL_RST=0, WAIT_LOCK=1, STABLE=2, REL_VIDEO=3, RUN=4, CPU_HOLD=5.

Decomposition:
- Package `pll_reset_pkg` holds:
  - the state enum and its encodings above;
  - the lock_loss_count width (8) and saturation value (255);
  - a `clog2`-based counter-width helper.
- Sub-module `sync_bit`: parameterised SYNC_STAGES flop chain with async clear. Instantiated twice, for pll_locked and user_reset.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=16, STAGE_GAP_CYCLES=8, SYNC_STAGES=2.
- Nominal bring-up: release rst; pll_locked rises 10 cycles later and stays high -> pll_rst high for exactly cycles 0-3. rst_video falls 2+16 cycles after pll_locked rises (±1 for sync). rst_cpu falls and ready rises 8 cycles after rst_video. lock_loss_count=0.
- Lock never arrives: pll_locked=0 -> pll_rst pulses 4 cycles high, then 100 low, repeating. Check 3 consecutive periods. Resets stay high throughout.
- Lock glitch during STABLE: locked drops for 3 cycles after 10 stable cycles -> state returns to WAIT_LOCK, the full 16-cycle count restarts, lock_loss_count stays 0.
- Lock loss in RUN: pll_locked low 5 cycles -> rst_video, rst_cpu =1 and ready=0 within sync+1 cycles, lock_loss_count=1. Full STABLE/REL_VIDEO sequence on relock. Forcing 300 losses -> count reads 255.
- User reset: user_reset high 20 cycles in RUN -> rst_cpu=1 and ready=0 within 3 cycles, rst_video stays 0. rst_cpu stays high until 8 cycles after user_reset_s falls. Re-pulsing user_reset at tail cycle 5 extends the hold.
- Async rst in RUN: assert rst mid-cycle -> all outputs reach reset values without waiting for a clock edge, and lock_loss_count clears.
